// File: rtl/latch_strobe_tx.sv
// Serialises a WIDTH-bit word LSB first onto d_out, pulsing en_out for STROBE_CYC cycles per bit
// so a downstream D latch captures each bit; STROBE_CYC+2 cycles per bit, in_ready low while busy.
module latch_strobe_tx #(
    parameter int WIDTH      = 8,
    parameter int STROBE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             d_out,
    output logic             en_out,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [SW-1:0] LAST_STB = SW'(STROBE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             armed;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word_sel;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nxt;
    logic [SW-1:0]    scnt;
    logic [SW-1:0]    scnt_nxt;
    logic             load;
    logic             done_nxt;
    logic             next_bit;
    logic             accept;

    // armed keeps in_ready low until the first edge after reset releases
    assign in_ready = armed && (state == IDLE);
    assign busy     = armed && (state != IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        scnt_nxt  = scnt;
        load      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    idx_nxt   = '0;
                    load      = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                scnt_nxt  = '0;
            end
            STROBE: begin
                if (scnt == LAST_STB) begin
                    state_nxt = HOLD;
                    scnt_nxt  = '0;
                end else begin
                    scnt_nxt = scnt + 1'b1;
                end
            end
            HOLD: begin
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = SETUP;
                    idx_nxt   = idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // New bit is selected from the incoming word on acceptance, otherwise from the held word
    always_comb begin
        word_sel = load ? in_data : sr;
        next_bit = word_sel[idx_nxt];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            armed  <= 1'b0;
            sr     <= '0;
            idx    <= '0;
            scnt   <= '0;
            d_out  <= 1'b0;
            en_out <= 1'b0;
            done   <= 1'b0;
        end else begin
            armed  <= 1'b1;
            state  <= state_nxt;
            idx    <= idx_nxt;
            scnt   <= scnt_nxt;
            done   <= done_nxt;
            en_out <= (state_nxt == STROBE);
            if (load) begin
                sr <= in_data;
            end
            // d_out only moves on entry to SETUP, never next to a strobe
            if (state_nxt == SETUP) begin
                d_out <= next_bit;
            end
        end
    end

endmodule

// File: tb/tb_latch_strobe_tx.sv
// Directed bench for latch_strobe_tx: an 8-bit/2-cycle instance and a 1-bit/1-cycle instance.
module tb_latch_strobe_tx;

    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, d_out, en_out, busy, done;
    logic [0:0] in_data_b;
    logic       in_valid_b;
    logic       in_ready_b, d_out_b, en_out_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0, done_cnt = 0, stb_cnt = 0, done_cnt_b = 0;
    int b0, d0, s0;
    logic latch_q = 1'b0;
    logic prev_en = 1'b0, prev_d = 1'b0, prev_ok = 1'b0;
    logic prev_en_b = 1'b0, prev_d_b = 1'b0;

    always #5 clk = ~clk;

    latch_strobe_tx #(.WIDTH(8), .STROBE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .d_out(d_out), .en_out(en_out), .busy(busy), .done(done)
    );

    latch_strobe_tx #(.WIDTH(1), .STROBE_CYC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .d_out(d_out_b), .en_out(en_out_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] w, input bit keep);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    // Walks every cycle of a word: SETUP, STROBE x SC, HOLD per bit
    task automatic expect_word(input logic [7:0] w, input bit wiggle);
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < SC + 2; c++) begin
                cyc();
                chk("bit_cycle", {busy, en_out, d_out}, {1'b1, (c >= 1 && c <= SC), w[b]});
                if (c == SC + 1) chk("latch_sample", latch_q, w[b]);
                if (wiggle) begin
                    in_data  = ~in_data;
                    in_valid = ~in_valid;
                end
            end
        end
        if (wiggle) in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        in_data_b  = 1'b0;
        in_valid_b = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (prev_ok && (en_out || prev_en)) chk("d_stable", d_out, prev_d);
                    if (prev_ok && (en_out_b || prev_en_b)) chk("d_stable_b", d_out_b, prev_d_b);
                    if (en_out) latch_q = d_out;
                    if (busy) busy_cnt++;
                    if (done) done_cnt++;
                    if (en_out && !prev_en) stb_cnt++;
                    if (done_b) done_cnt_b++;
                end
                prev_ok   = rst_n;
                prev_en   = en_out;
                prev_d    = d_out;
                prev_en_b = en_out_b;
                prev_d_b  = d_out_b;
            end
        join_none

        // Reset state and release
        #3;
        chk("rst_outs", {d_out, en_out, busy, done, in_ready}, 5'b0);
        chk("rst_outs_b", {d_out_b, en_out_b, busy_b, done_b, in_ready_b}, 5'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("ready_before_edge", in_ready, 1'b0);
        cyc();
        chk("ready_after_edge", {in_ready, busy, done, en_out, d_out}, 5'b10000);
        chk("ready_after_edge_b", in_ready_b, 1'b1);

        // 0xA5 single word
        b0 = busy_cnt; d0 = done_cnt; s0 = stb_cnt;
        present(8'hA5, 1'b0);
        expect_word(8'hA5, 1'b0);
        cyc();
        chk("done_a5", {done, busy, in_ready, en_out, d_out}, 5'b10101);
        chk("busy_cycles_a5", busy_cnt - b0, 32);
        chk("strobes_a5", stb_cnt - s0, 8);
        chk("done_count_a5", done_cnt - d0, 1);
        cyc();
        chk("idle_after_a5", {done, busy, in_ready, d_out}, 4'b0011);

        // 0x3C then 0xC3, valid held so the second word goes in on the done edge
        b0 = busy_cnt; d0 = done_cnt;
        present(8'h3C, 1'b1);
        in_data = 8'hC3;
        expect_word(8'h3C, 1'b0);
        cyc();
        chk("done_b2b_first", {done, busy, in_ready}, 3'b101);
        @(posedge clk);
        #1 in_valid = 1'b0;
        expect_word(8'hC3, 1'b0);
        cyc();
        chk("done_b2b_second", {done, busy, d_out}, 3'b101);
        chk("busy_cycles_b2b", busy_cnt - b0, 64);
        chk("done_count_b2b", done_cnt - d0, 2);

        // Inputs wiggled while busy must not disturb the captured word
        present(8'h96, 1'b1);
        expect_word(8'h96, 1'b1);
        cyc();
        chk("done_wiggle", {done, busy, d_out}, 3'b101);
        d0 = done_cnt;
        cyc();
        chk("no_extra_accept", {busy, in_ready, done}, 3'b010);
        chk("done_count_wiggle", done_cnt - d0, 0);

        // Reset in the first strobe cycle of bit 3
        d0 = done_cnt;
        present(8'h5A, 1'b0);
        repeat (14) cyc();
        chk("strobe_bit3", {busy, en_out, d_out}, 3'b111);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_outs", {d_out, en_out, busy, done, in_ready}, 5'b0);
        cyc();
        cyc();
        chk("held_rst_outs", {d_out, en_out, busy, done, in_ready}, 5'b0);
        rst_n = 1'b1;
        #1 chk("ready_low_after_release", in_ready, 1'b0);
        cyc();
        chk("ready_high_after_release", in_ready, 1'b1);
        chk("no_done_on_abort", done_cnt - d0, 0);
        present(8'hFF, 1'b0);
        expect_word(8'hFF, 1'b0);
        cyc();
        chk("done_ff", {done, busy, in_ready, d_out}, 4'b1011);
        chk("done_count_ff", done_cnt - d0, 1);

        // WIDTH=1, STROBE_CYC=1
        in_data_b  = 1'b1;
        in_valid_b = 1'b1;
        @(posedge clk);
        #1 in_valid_b = 1'b0;
        cyc();
        chk("w1_setup", {busy_b, en_out_b, d_out_b}, 3'b101);
        cyc();
        chk("w1_strobe", {busy_b, en_out_b, d_out_b}, 3'b111);
        cyc();
        chk("w1_hold", {busy_b, en_out_b, d_out_b}, 3'b101);
        cyc();
        chk("w1_done", {done_b, busy_b, in_ready_b, d_out_b}, 4'b1011);
        chk("w1_done_count", done_cnt_b, 1);
        cyc();
        chk("w1_idle", {done_b, busy_b, d_out_b}, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
